// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int unsigned TO_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StStart,
        StWait,
        StGap
    } sched_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Pops bytes from a show-ahead TX FIFO, starts one UART frame per byte and
// waits for completion, honouring enable, CTS flow control and an optional gap.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned TIMEOUT    = 20000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              cts_n_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_rdata_i,
    output logic              fifo_rd_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_done_i,
    output logic              busy_o,
    output logic              drained_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic              proto_err_o
);

    localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] ToLast  = TO_W'(TIMEOUT - 1);

    sched_state_t      state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              drained_q, drained_d;
    logic              cts_s;
    logic              cts_ok;

    // Resets to 1 so the link is treated as not clear until CTS is really seen.
    sync_2ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_cts_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cts_n_i),
        .q_o    (cts_s)
    );

    assign cts_ok = ~cts_s;

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        proto_err_d = proto_err_q;
        drained_d   = 1'b0;
        fifo_rd_o   = 1'b0;

        if (tx_done_i && (state_q != StWait)) begin
            proto_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (en_i && cts_ok && !fifo_empty_i) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                // An empty FIFO here means the FIFO broke the show-ahead contract.
                if (fifo_empty_i) begin
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    fifo_rd_o = 1'b1;
                    tx_data_d = fifo_rdata_i;
                    state_d   = StStart;
                end
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StWait;
            end
            StWait: begin
                if (tx_done_i) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        drained_d = fifo_empty_i;
                        state_d   = StIdle;
                    end
                end else if (to_cnt_q == ToLast) begin
                    proto_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    drained_d = fifo_empty_i;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            tx_data_q   <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            frame_cnt_q <= '0;
            proto_err_q <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            proto_err_q <= proto_err_d;
            drained_q   <= drained_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = (state_q == StStart);
    assign busy_o      = (state_q != StIdle);
    assign drained_o   = drained_q;
    assign frame_cnt_o = frame_cnt_q;
    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: two schedulers (no gap / 4-cycle gap) share stimulus, each
// with its own FIFO and transmitter model.
module tb_uart_tx_sched;

    localparam int To = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, cts_n, stray, withhold;
    logic       fifo_empty [2];
    logic       fifo_rd    [2];
    logic       tx_start   [2];
    logic       tx_done    [2];
    logic       tx_m       [2] = '{1'b0, 1'b0};
    logic       busy       [2];
    logic       drained    [2];
    logic       proto_err  [2];
    logic [7:0] fifo_rdata [2];
    logic [7:0] tx_data    [2];
    logic [3:0] frame_cnt  [2];

    logic [7:0] mem [2][64];
    int rp  [2] = '{0, 0};
    int wp  [2] = '{0, 0};
    int dly [2] = '{0, 0};

    int cyc = 0;
    int rd_cnt [2] = '{0, 0};
    int st_cnt [2] = '{0, 0};
    int dr_cnt [2] = '{0, 0};
    int rd_cyc [2], st_cyc [2], done_cyc [2], gap_meas [2], pe_cyc [2];
    bit done_seen [2] = '{1'b0, 1'b0};
    bit pe_prev   [2] = '{1'b0, 1'b0};
    logic [7:0] log_q [2][64];

    int errors = 0;
    int checks = 0;
    int c0;

    uart_tx_sched #(
        .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT(To), .CNT_W(4)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cts_n_i(cts_n),
        .fifo_empty_i(fifo_empty[0]), .fifo_rdata_i(fifo_rdata[0]), .fifo_rd_o(fifo_rd[0]),
        .tx_data_o(tx_data[0]), .tx_start_o(tx_start[0]), .tx_done_i(tx_done[0]),
        .busy_o(busy[0]), .drained_o(drained[0]), .frame_cnt_o(frame_cnt[0]),
        .proto_err_o(proto_err[0])
    );

    uart_tx_sched #(
        .DATA_W(8), .GAP_CYCLES(4), .TIMEOUT(To), .CNT_W(4)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cts_n_i(cts_n),
        .fifo_empty_i(fifo_empty[1]), .fifo_rdata_i(fifo_rdata[1]), .fifo_rd_o(fifo_rd[1]),
        .tx_data_o(tx_data[1]), .tx_start_o(tx_start[1]), .tx_done_i(tx_done[1]),
        .busy_o(busy[1]), .drained_o(drained[1]), .frame_cnt_o(frame_cnt[1]),
        .proto_err_o(proto_err[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = (rp[k] == wp[k]);
            fifo_rdata[k] = mem[k][rp[k] % 64];
            tx_done[k]    = tx_m[k] | stray;
        end
    end

    // FIFO pop and transmitter: tx_done 10 cycles after tx_start unless withheld.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (fifo_rd[k]) rp[k] <= rp[k] + 1;
            if (tx_start[k]) dly[k] <= 10;
            else if (dly[k] > 0) dly[k] <= dly[k] - 1;
            tx_m[k] <= (dly[k] == 2) && !withhold;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fifo_rd[k] === 1'b1) begin
                rd_cnt[k]++;
                rd_cyc[k] = cyc;
                if (done_seen[k]) begin
                    gap_meas[k]  = cyc - done_cyc[k];
                    done_seen[k] = 1'b0;
                end
            end
            if (tx_start[k] === 1'b1) begin
                log_q[k][st_cnt[k] % 64] = tx_data[k];
                st_cnt[k]++;
                st_cyc[k] = cyc;
            end
            if (tx_done[k] === 1'b1) begin
                done_cyc[k]  = cyc;
                done_seen[k] = 1'b1;
            end
            if (drained[k] === 1'b1) dr_cnt[k]++;
            if ((proto_err[k] === 1'b1) && !pe_prev[k]) pe_cyc[k] = cyc;
            pe_prev[k] = (proto_err[k] === 1'b1);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            mem[k][wp[k] % 64] = b;
            wp[k]++;
        end
    endtask

    task automatic wait_drain(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dr_cnt[0] >= target && dr_cnt[1] >= target) break;
            tick();
        end
        for (int k = 0; k < 2; k++) check_eq($sformatf("drained_cnt%0d", k), dr_cnt[k], target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; cts_n = 1'b0; stray = 1'b0; withhold = 1'b0;
        push(8'h41);
        push(8'h42);
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_busy%0d", k), busy[k], 0);
            check_eq($sformatf("rst_fifo_rd%0d", k), fifo_rd[k], 0);
            check_eq($sformatf("rst_tx_start%0d", k), tx_start[k], 0);
            check_eq($sformatf("rst_tx_data%0d", k), tx_data[k], 0);
            check_eq($sformatf("rst_drained%0d", k), drained[k], 0);
            check_eq($sformatf("rst_frame_cnt%0d", k), frame_cnt[k], 0);
            check_eq($sformatf("rst_proto_err%0d", k), proto_err[k], 0);
        end

        // Two-byte burst
        rst_n = 1'b1;
        wait_drain(1, 300);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("burst_rd_cnt%0d", k), rd_cnt[k], 2);
            check_eq($sformatf("burst_byte0_%0d", k), log_q[k][0], 8'h41);
            check_eq($sformatf("burst_byte1_%0d", k), log_q[k][1], 8'h42);
            check_eq($sformatf("burst_frames%0d", k), frame_cnt[k], 2);
            check_eq($sformatf("burst_proto_err%0d", k), proto_err[k], 0);
            check_eq($sformatf("rd_to_start%0d", k), st_cyc[k] - rd_cyc[k], 1);
        end
        check_eq("done_to_rd_nogap", gap_meas[0], 2);
        check_eq("done_to_rd_gap4", gap_meas[1], 6);

        // CTS flow control
        cts_n = 1'b1;
        repeat (3) tick();
        push(8'h55);
        repeat (20) tick();
        for (int k = 0; k < 2; k++) check_eq($sformatf("cts_block%0d", k), rd_cnt[k], 2);
        c0 = cyc;
        cts_n = 1'b0;
        for (int i = 0; i < 20 && (rd_cnt[0] < 3 || rd_cnt[1] < 3); i++) tick();
        for (int k = 0; k < 2; k++) check_eq($sformatf("cts_latency%0d", k), rd_cyc[k] - c0, 3);
        wait_drain(2, 300);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("cts_byte%0d", k), log_q[k][2], 8'h55);
            check_eq($sformatf("cts_frames%0d", k), frame_cnt[k], 3);
        end

        // Completion timeout
        withhold = 1'b1;
        push(8'h5a);
        for (int i = 0; i < 20 && (st_cnt[0] < 4 || st_cnt[1] < 4); i++) tick();
        for (int i = 0; i < 100 && !(proto_err[0] === 1'b1 && proto_err[1] === 1'b1); i++) tick();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("to_latency%0d", k), pe_cyc[k] - (st_cyc[k] + 1), To);
            check_eq($sformatf("to_idle%0d", k), busy[k], 0);
            check_eq($sformatf("to_frames%0d", k), frame_cnt[k], 3);
            check_eq($sformatf("to_no_drain%0d", k), dr_cnt[k], 2);
        end

        // Asynchronous reset in WAIT
        push(8'h77);
        for (int i = 0; i < 20 && (st_cnt[0] < 5 || st_cnt[1] < 5); i++) tick();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("arst_busy%0d", k), busy[k], 0);
            check_eq($sformatf("arst_tx_start%0d", k), tx_start[k], 0);
            check_eq($sformatf("arst_proto_err%0d", k), proto_err[k], 0);
            check_eq($sformatf("arst_frames%0d", k), frame_cnt[k], 0);
        end
        tick();
        push(8'h88);
        repeat (12) tick();
        withhold = 1'b0;
        rst_n = 1'b1;
        wait_drain(3, 300);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("post_rst_byte%0d", k), log_q[k][5], 8'h88);
            check_eq($sformatf("post_rst_frames%0d", k), frame_cnt[k], 1);
            check_eq($sformatf("post_rst_proto_err%0d", k), proto_err[k], 0);
        end

        // Stray tx_done while idle
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("stray_proto_err%0d", k), proto_err[k], 1);
            check_eq($sformatf("stray_frames%0d", k), frame_cnt[k], 1);
        end

        // Frame counter wrap at CNT_W=4
        for (int i = 0; i < 14; i++) push(8'(i));
        wait_drain(4, 800);
        for (int k = 0; k < 2; k++) check_eq($sformatf("cnt_all_ones%0d", k), frame_cnt[k], 15);
        push(8'hee);
        wait_drain(5, 100);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("cnt_wrap%0d", k), frame_cnt[k], 0);
            check_eq($sformatf("sticky_proto_err%0d", k), proto_err[k], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
